// File: rtl/lc_otp_prog_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc_otp_prog_pkg
// Description : FSM state encodings and helpers for lc_otp_prog_initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package lc_otp_prog_pkg;

    localparam int unsigned c_STATE_WIDTH = 6;

    // Sparse encodings, every pair differs in at least three bits
    localparam logic [c_STATE_WIDTH-1:0] c_IDLE_ENC  = 6'b101001;
    localparam logic [c_STATE_WIDTH-1:0] c_REQ_ENC   = 6'b010011;
    localparam logic [c_STATE_WIDTH-1:0] c_DONE_ENC  = 6'b110100;
    localparam logic [c_STATE_WIDTH-1:0] c_ERROR_ENC = 6'b001110;

    typedef enum logic [c_STATE_WIDTH-1:0] {
        IdleSt  = c_IDLE_ENC,
        ReqSt   = c_REQ_ENC,
        DoneSt  = c_DONE_ENC,
        ErrorSt = c_ERROR_ENC
    } lc_otp_prog_state_e;

    // Counter width able to hold 0..timeout, never narrower than one bit
    function automatic int unsigned tmo_cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : lc_otp_prog_pkg
`default_nettype wire

// File: rtl/otp_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otp_ctrl_pkg
// Description : Life-cycle state/count encodings and the LC program port
//               request/response types shared with the OTP controller.
// Revision    : 1.0 - initial release
// ============================================================================
package otp_ctrl_pkg;

    // Life-cycle states as programmed into OTP (compact encodings)
    typedef enum logic [15:0] {
        LcStRaw           = 16'h0000,
        LcStTestUnlocked0 = 16'h1c3a,
        LcStDev           = 16'h2e55,
        LcStProd          = 16'h4b93,
        LcStProdEnd       = 16'h76a1,
        LcStRma           = 16'h8d4c,
        LcStScrap         = 16'hf0e7
    } lc_state_e;

    // Life-cycle transition counter values
    typedef enum logic [7:0] {
        LcCnt0 = 8'h00,
        LcCnt1 = 8'h13,
        LcCnt2 = 8'h25,
        LcCnt3 = 8'h36,
        LcCnt4 = 8'h4a,
        LcCnt5 = 8'h59,
        LcCnt6 = 8'h6f,
        LcCnt7 = 8'h7c
    } lc_cnt_e;

    typedef struct packed {
        logic      req;
        lc_state_e state;
        lc_cnt_e   count;
    } lc_otp_program_req_t;

    typedef struct packed {
        logic err;
        logic ack;
    } lc_otp_program_rsp_t;

endpackage : otp_ctrl_pkg
`default_nettype wire

// File: rtl/lc_otp_prog_tmo_cnt.sv
`default_nettype none
// ============================================================================
// Module      : lc_otp_prog_tmo_cnt
// Description : Saturating timeout counter with clear, enable and an
//               expired flag. LIMIT = 0 disables it (held at zero).
// Revision    : 1.0 - initial release
// ============================================================================
module lc_otp_prog_tmo_cnt #(
    parameter int unsigned LIMIT = 4096,
    parameter int unsigned WIDTH = 13
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    // Count value at which the wait is considered expired; also the saturation point
    localparam logic [WIDTH-1:0] c_LAST = (LIMIT == 0) ? '0 : WIDTH'(LIMIT - 1);

    logic [WIDTH-1:0] r_cnt;

    // Count while enabled, stop at the last value so it never wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i && (LIMIT != 0) && (r_cnt != c_LAST)) begin
            r_cnt <= r_cnt + WIDTH'(1);
        end
    end

    generate
        if (LIMIT != 0) begin : g_tmo_on
            assign expired_o = (r_cnt == c_LAST);
        end else begin : g_tmo_off
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule : lc_otp_prog_tmo_cnt
`default_nettype wire

// File: rtl/lc_otp_prog_initiator.sv
`default_nettype none
// ============================================================================
// Module      : lc_otp_prog_initiator
// Description : LC-side initiator of the OTP life-cycle program handshake.
//               Latches a one-shot command, holds a stable request until
//               ack or timeout, and reports done/err/timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module lc_otp_prog_initiator
    import otp_ctrl_pkg::*;
    import lc_otp_prog_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned TMO_CNT_WIDTH  = tmo_cnt_width(TIMEOUT_CYCLES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  lc_state_e           target_state_i,
    input  lc_cnt_e             target_count_i,
    output lc_otp_program_req_t lc_otp_program_o,
    input  lc_otp_program_rsp_t lc_otp_program_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic                timeout_o,
    output logic                spurious_ack_o,
    output logic                fsm_err_o
);

    lc_otp_prog_state_e r_state;
    lc_otp_prog_state_e w_state_next;

    lc_state_e r_tgt_state;
    lc_cnt_e   r_tgt_count;

    logic r_req;
    logic r_busy;
    logic r_done;
    logic r_err;
    logic r_timeout;
    logic r_spurious;
    logic r_fsm_err;

    logic w_accept;
    logic w_done_err;
    logic w_done_tmo;
    logic w_tmo_expired;

    lc_otp_prog_tmo_cnt #(
        .LIMIT (TIMEOUT_CYCLES),
        .WIDTH (TMO_CNT_WIDTH)
    ) u_tmo_cnt (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clr_i     (w_accept),
        .en_i      (r_state == ReqSt),
        .expired_o (w_tmo_expired)
    );

    // Next-state logic; ack takes priority over the timeout boundary
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_done_err   = 1'b0;
        w_done_tmo   = 1'b0;
        case (r_state)
            IdleSt: begin
                if (start_i) begin
                    w_accept     = 1'b1;
                    w_state_next = ReqSt;
                end
            end
            ReqSt: begin
                if (lc_otp_program_i.ack) begin
                    w_state_next = DoneSt;
                    w_done_err   = lc_otp_program_i.err;
                end else if (w_tmo_expired) begin
                    w_state_next = DoneSt;
                    w_done_err   = 1'b1;
                    w_done_tmo   = 1'b1;
                end
            end
            DoneSt:  w_state_next = IdleSt;
            ErrorSt: w_state_next = ErrorSt;
            default: w_state_next = ErrorSt;
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= IdleSt;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Command latch; reloads only on an accepted start
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_tgt_state <= lc_state_e'('0);
            r_tgt_count <= lc_cnt_e'('0);
        end else if (w_accept) begin
            r_tgt_state <= target_state_i;
            r_tgt_count <= target_count_i;
        end
    end

    // Registered outputs derived from the state being entered
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_req      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_timeout  <= 1'b0;
            r_spurious <= 1'b0;
            r_fsm_err  <= 1'b0;
        end else begin
            r_req      <= (w_state_next == ReqSt);
            r_busy     <= (w_state_next == ReqSt);
            r_done     <= (w_state_next == DoneSt);
            r_err      <= w_done_err;
            r_timeout  <= w_done_tmo;
            r_spurious <= lc_otp_program_i.ack && (r_state != ReqSt);
            r_fsm_err  <= r_fsm_err || (w_state_next == ErrorSt);
        end
    end

    assign lc_otp_program_o.req   = r_req;
    assign lc_otp_program_o.state = r_tgt_state;
    assign lc_otp_program_o.count = r_tgt_count;

    assign busy_o         = r_busy;
    assign done_o         = r_done;
    assign err_o          = r_err;
    assign timeout_o      = r_timeout;
    assign spurious_ack_o = r_spurious;
    assign fsm_err_o      = r_fsm_err;

endmodule : lc_otp_prog_initiator
`default_nettype wire

// File: doc/lc_otp_prog_initiator.md
Name: lc_otp_prog_initiator

Overview:
- Life-cycle-side initiator for the OTP life-cycle programming handshake. It drives lc_otp_program_req_t and consumes lc_otp_program_rsp_t from otp_ctrl_pkg.
- Accepts a one-shot transition command (target state and count) from the LC transition FSM and holds a stable request until otp_ctrl acks.
- Reports completion and error, and guards against a hung responder with a timeout.
- Sits inside the LC controller, directly facing the OTP controller's LC program port.

Parameters:
- TimeoutCycles, 4096, number of cycles to wait for ack after req rises; 0 disables the timeout.
- TmoCntWidth, $clog2(TimeoutCycles+1) (min 1), derived width of the timeout counter; not to be overridden.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  single-cycle command strobe.
- target_state_i  in  lc_state_e  state to program, sampled on an accepted start.
- target_count_i  in  lc_cnt_e  transition count to program, sampled on an accepted start.
- lc_otp_program_o  out  lc_otp_program_req_t  req, state, count to otp_ctrl.
- lc_otp_program_i  in  lc_otp_program_rsp_t  ack, err from otp_ctrl.
- busy_o  out  1  high from the accepted start until done.
- done_o  out  1  one-cycle completion pulse.
- err_o  out  1  valid with done_o: responder err or timeout.
- timeout_o  out  1  valid with done_o: completion was caused by timeout.
- spurious_ack_o  out  1  one-cycle pulse when ack arrives outside ReqSt.
- fsm_err_o  out  1  sticky; FSM reached an invalid encoding.

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- All outputs are registered. At reset every output is 0, and req/state/count are all-zero bit patterns.
- FSM states, sparse-encoded with Hamming distance >= 3: IdleSt, ReqSt, DoneSt, ErrorSt.
- IdleSt:
  - start_i=1 latches target_state_i and target_count_i, clears the counter, and moves to ReqSt.
  - req=1 appears on the next cycle: start at cycle 0 -> req at cycle 1.
- ReqSt:
  - req=1; state and count are driven from the latched registers and stay stable while req is high.
  - The counter increments every cycle.
  - ack=1 moves to DoneSt. err_o is set to lc_otp_program_i.err, and req=0 on the next cycle.
  - If TimeoutCycles!=0, the counter reaches TimeoutCycles-1 and ack=0, the FSM moves to DoneSt with err_o=1 and timeout_o=1, and req drops.
  - If ack arrives in the same cycle as the timeout boundary, ack wins and timeout_o=0.
- DoneSt:
  - Lasts exactly one cycle with done_o=1; busy_o=0 in this cycle; then returns to IdleSt.
  - Ack at cycle N -> done_o and req=0 at cycle N+1.
- Latched state and count hold their last values after completion. They only reload on the next accepted start.
- busy_o=1 in ReqSt only.
- start_i is ignored in ReqSt and DoneSt: no queueing and no error.
- Ack while not in ReqSt: ignored by the FSM, pulses spurious_ack_o on the next cycle.
- err without ack: ignored.
- ErrorSt:
  - Entered from any invalid encoding.
  - Terminal until reset: req=0, busy_o=0, fsm_err_o=1, start ignored.
- Reset asserted mid-transaction: req deasserts asynchronously, no done_o is produced, and the FSM returns to IdleSt after reset.
- The counter saturates and never wraps. With TimeoutCycles=0 it is held at 0.

Decomposition:
- The FSM state enum and its encoding constants go in a shared lc_otp_prog_pkg.
- lc_otp_program_req_t and lc_otp_program_rsp_t are reused from otp_ctrl_pkg.
- One sub-module, lc_otp_prog_tmo_cnt: a saturating counter with clear, enable and an expired flag.

Test Plan:
- Basic: start with state=LcStProd, count=LcCnt5; ack at cycle 6 with err=0 -> req high over cycles 1-6, done_o=1 and err_o=0 at cycle 7, outputs hold LcStProd/LcCnt5.
- Error: same flow with ack and err=1 at cycle 3 -> done_o=1, err_o=1, timeout_o=0 at cycle 4.
- Timeout: TimeoutCycles=16, no ack -> req falls and done_o=err_o=timeout_o=1 at cycle 17. Ack at the boundary cycle instead gives timeout_o=0.
- Protocol robustness: start during busy changes nothing; ack pulsed while idle -> spurious_ack_o=1 for one cycle and no done_o.
- Reset: rst_ni low at cycle 3 of ReqSt -> req=0 immediately. A new start after reset completes normally.
- FSM fault: force an invalid state encoding -> fsm_err_o=1, req=0, further starts ignored until reset.
